decode_stage: RTL
=================

# decode_stage

Buffered, handshaked decode stage sitting between fetch and dispatch/execute. It accepts one instruction per cycle into an instruction buffer and decodes the buffer head into a `uop_info_t`. The result is held in a registered output slot with valid/ready flow control. It generalises the single-cycle combinational decoder in three ways: parametrised XLEN with RV64 word ops, an optional M extension, and illegal-instruction and ecall flagging. Flush support is added for redirects.

## Interface
Parameters:
- `XLEN`, 32: datapath width; 32 or 64 only. 64 enables LD/LWU/SD and the OP-IMM-32/OP-32 word ops.
- `IBUF_DEPTH`, 4: instruction buffer entries; power of two, ≥2.
- `EN_M`, 1: 1 = decode RV M extension; 0 = M encodings are illegal.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous active-high reset.
- `flush_i` in 1: discard all buffered and held instructions.
- `fetch_valid_i` in 1: fetch offers `pc_i`/`inst_i`.
- `fetch_ready_o` out 1: buffer can accept.
- `pc_i` in XLEN: instruction PC.
- `inst_i` in 32: instruction word.
- `uop_valid_o` out 1: `uop_info_o` is valid.
- `uop_ready_i` in 1: consumer takes the uop.
- `uop_info_o` out `$bits(uop_info_t)`: decoded uop, including `illegal` and `ecall`.
- `ibuf_count_o` out `$clog2(IBUF_DEPTH)+1`: buffer occupancy.

## Operation
- Enqueue occurs when `fetch_valid_i && fetch_ready_o`. `fetch_ready_o = !flush_i && (count < IBUF_DEPTH)`. It has no path from `uop_ready_i`.
- The buffer is a circular FIFO with read/write pointers that wrap modulo `IBUF_DEPTH`. Simultaneous enqueue and dequeue keeps the count unchanged.
- The buffer head is decoded combinationally. It is loaded into the output slot when the head is valid and the slot is empty or being drained (`!uop_valid_o || uop_ready_i`). Loading dequeues the head.
- Output slot: `uop_valid_o` and `uop_info_o` stay stable until `uop_ready_i`. A back-to-back drain and load sustains 1 uop/cycle.
- Decode adds the following on top of RV32I:
  - OP with fun7=0000001 → `fu=FU_MDU`, funcs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, gated by `EN_M`.
  - OP-IMM-32 (0011011) and OP-32 (0111011) → ADDIW/SLLIW/SRLIW/SRAIW/ADDW/SUBW/SLLW/SRLW/SRAW, plus MULW/DIVW/DIVUW/REMW/REMUW when `EN_M`. All of these are legal only when XLEN=64.
  - LOAD fun3 011/110 → LOAD_LD/LOAD_LWU and STORE fun3 011 → STORE_SD, legal only when XLEN=64.
  - Shift immediates: shamt is inst[25:20] when XLEN=64. When XLEN=32, inst[25]=1 is illegal.
  - `ecall` is asserted iff inst==0x00000073. `ebreak` is asserted iff inst==0x00100073.
- Illegal conditions: unknown opcode, undefined fun3/fun7, or a disabled extension. An illegal uop has `illegal=1`, `fu=FU_NONE`, `rd_wen=0`, and `pc`/`inst` preserved. It still flows through the handshake.
- `rd_wen = !(BRANCH|STORE) && rd!=0 && !illegal`.
- Immediates are sign-extended to XLEN. U-type is sign-extended from bit 31.

## Timing
- Reset (synchronous): pointers=0, `ibuf_count_o`=0, `uop_valid_o`=0, `uop_info_o`=all zero (OP_NONE/FUNC_NONE/FU_NONE). `fetch_ready_o`=1 in the first cycle after reset deasserts.
- Latency: an instruction enqueued at edge N is visible on `uop_valid_o` after edge N+1. There is no same-cycle bypass.
- Capacity is `IBUF_DEPTH` + 1 (the output slot).
- `flush_i` at edge N: buffer emptied and `uop_valid_o`=0 after N. An enqueue in the same cycle is blocked, because ready is low. `uop_ready_i` in the same cycle is ignored. Flush takes priority over everything except reset.
- Reset mid-stream behaves identically to flush and also clears `uop_info_o`.

## Structure
- Add to the shared package:
  - `FU_MDU`.
  - M and W `fu_func_e` members.
  - `LOAD_LD`, `LOAD_LWU`, `STORE_SD`.
  - An `illegal` field in `uop_info_t`.
  - The opcode constants `OPC_OP_IMM_32` and `OPC_OP_32`.
- Sub-module `rv_decode_core`: purely combinational, parametrised by XLEN and EN_M. It maps pc/inst to `uop_info_t`.
- FIFO and output slot live in `decode_stage`.

## Test plan
- Single instruction: reset, push pc=0x80000000 inst=0x02A00093 (addi x1,x0,42). Required at N+1: `uop_valid_o`=1, ADDI, rd=1, rd_wen=1, imm=42.
- M gating: push 0x022081B3 (mul x3,x1,x2). With EN_M=1 → fu=FU_MDU, MUL, rd=3. With EN_M=0 → illegal=1, rd_wen=0.
- RV64 word op: push 0x0010809B (addiw x1,x1,1). With XLEN=64 → ADDIW, imm=1. With XLEN=32 → illegal=1.
- Backpressure: hold `uop_ready_i`=0 and push 6 instructions at IBUF_DEPTH=4. Required: 5 accepted, then `fetch_ready_o`=0 and count=4. Release ready → 5 uops out in order, 1/cycle, and pointers wrap correctly.
- Flush: with 3 queued and one held, assert `flush_i` one cycle alongside `fetch_valid_i`. Required next cycle: `uop_valid_o`=0, count=0, nothing enqueued.
- System ops: push 0x00000073 → ecall=1; push 0x00100073 → ebreak=1. Mid-stream `rst_i` → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode types: opcodes, uop classification enums, decoded uop record
// and immediate sign-extension helpers.
package decode_stage_pkg;

  // Decoded PC/immediate fields are sized for the widest supported XLEN;
  // an XLEN=32 build zero-extends the PC and sign-extends immediates.
  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [3:0] {
    OP_NONE, OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
    OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM
  } op_type_e;

  typedef enum logic [2:0] {
    FU_NONE, FU_ALU, FU_BRU, FU_LSU, FU_MDU, FU_SYS
  } fu_e;

  typedef enum logic [6:0] {
    FUNC_NONE,
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND,
    ALU_ADDI, ALU_SLTI, ALU_SLTIU, ALU_XORI, ALU_ORI, ALU_ANDI,
    ALU_SLLI, ALU_SRLI, ALU_SRAI,
    ALU_LUI, ALU_AUIPC,
    ALU_ADDIW, ALU_SLLIW, ALU_SRLIW, ALU_SRAIW,
    ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW,
    BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU, BR_JAL, BR_JALR,
    LOAD_LB, LOAD_LH, LOAD_LW, LOAD_LBU, LOAD_LHU, LOAD_LD, LOAD_LWU,
    STORE_SB, STORE_SH, STORE_SW, STORE_SD,
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
    MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU,
    MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW,
    SYS_FENCE, SYS_ECALL, SYS_EBREAK
  } fu_func_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [31:0]         inst;
    op_type_e            op;
    fu_e                 fu;
    fu_func_e            func;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                rd_wen;
    logic [XLEN_MAX-1:0] imm;
    logic                illegal;
    logic                ecall;
    logic                ebreak;
  } uop_info_t;

  // I-type immediate, inst[31:20]
  function automatic logic [63:0] imm_i(input logic [11:0] f);
    return {{52{f[11]}}, f};
  endfunction

  // S-type immediate, {inst[31:25], inst[11:7]}
  function automatic logic [63:0] imm_s(input logic [6:0] hi, input logic [4:0] lo);
    return {{52{hi[6]}}, hi, lo};
  endfunction

  // B-type immediate, bits [12:1] already gathered by the caller
  function automatic logic [63:0] imm_b(input logic [12:1] b);
    return {{51{b[12]}}, b, 1'b0};
  endfunction

  // U-type immediate, sign-extended from inst[31]
  function automatic logic [63:0] imm_u(input logic [19:0] u);
    return {{32{u[19]}}, u, 12'h000};
  endfunction

  // J-type immediate, bits [20:1] already gathered by the caller
  function automatic logic [63:0] imm_j(input logic [20:1] j);
    return {{43{j[20]}}, j, 1'b0};
  endfunction

endpackage

// File: rtl/decode_stage_rv_decode_core.sv
// Purely combinational RV32I/RV64I(+M) decoder mapping pc/inst to a uop record.
// Anything unrecognised, or belonging to a disabled extension/width, is
// flagged illegal with its pc/inst kept for the trap path.
module rv_decode_core
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b1
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_inst,
  output uop_info_t       o_uop
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]  w_opc;
  logic [6:0]  w_fun7;
  logic [2:0]  w_fun3;
  logic        w_ill;
  op_type_e    w_op;
  fu_e         w_fu;
  fu_func_e    w_func;
  logic [63:0] w_imm;

  assign w_opc  = i_inst[6:0];
  assign w_fun3 = i_inst[14:12];
  assign w_fun7 = i_inst[31:25];

  // Opcode/funct decode into class, unit, function, immediate and legality
  always_comb begin
    w_ill  = 1'b0;
    w_op   = OP_NONE;
    w_fu   = FU_NONE;
    w_func = FUNC_NONE;
    w_imm  = 64'd0;
    case (w_opc)
      OPC_LUI: begin
        w_op = OP_LUI; w_fu = FU_ALU; w_func = ALU_LUI;
        w_imm = imm_u(i_inst[31:12]);
      end
      OPC_AUIPC: begin
        w_op = OP_AUIPC; w_fu = FU_ALU; w_func = ALU_AUIPC;
        w_imm = imm_u(i_inst[31:12]);
      end
      OPC_JAL: begin
        w_op = OP_JAL; w_fu = FU_BRU; w_func = BR_JAL;
        w_imm = imm_j({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21]});
      end
      OPC_JALR: begin
        w_op = OP_JALR; w_fu = FU_BRU; w_func = BR_JALR;
        w_imm = imm_i(i_inst[31:20]);
        if (w_fun3 != 3'b000) w_ill = 1'b1;
        else                  w_ill = 1'b0;
      end
      OPC_BRANCH: begin
        w_op = OP_BRANCH; w_fu = FU_BRU;
        w_imm = imm_b({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8]});
        case (w_fun3)
          3'b000:  w_func = BR_BEQ;
          3'b001:  w_func = BR_BNE;
          3'b100:  w_func = BR_BLT;
          3'b101:  w_func = BR_BGE;
          3'b110:  w_func = BR_BLTU;
          3'b111:  w_func = BR_BGEU;
          default: w_ill  = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_op = OP_LOAD; w_fu = FU_LSU;
        w_imm = imm_i(i_inst[31:20]);
        case (w_fun3)
          3'b000:  w_func = LOAD_LB;
          3'b001:  w_func = LOAD_LH;
          3'b010:  w_func = LOAD_LW;
          3'b100:  w_func = LOAD_LBU;
          3'b101:  w_func = LOAD_LHU;
          3'b011: begin
            if (RV64) w_func = LOAD_LD;
            else      w_ill  = 1'b1;
          end
          3'b110: begin
            if (RV64) w_func = LOAD_LWU;
            else      w_ill  = 1'b1;
          end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        w_op = OP_STORE; w_fu = FU_LSU;
        w_imm = imm_s(i_inst[31:25], i_inst[11:7]);
        case (w_fun3)
          3'b000:  w_func = STORE_SB;
          3'b001:  w_func = STORE_SH;
          3'b010:  w_func = STORE_SW;
          3'b011: begin
            if (RV64) w_func = STORE_SD;
            else      w_ill  = 1'b1;
          end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        w_op = OP_IMM; w_fu = FU_ALU;
        w_imm = imm_i(i_inst[31:20]);
        case (w_fun3)
          3'b000: w_func = ALU_ADDI;
          3'b010: w_func = ALU_SLTI;
          3'b011: w_func = ALU_SLTIU;
          3'b100: w_func = ALU_XORI;
          3'b110: w_func = ALU_ORI;
          3'b111: w_func = ALU_ANDI;
          3'b001: begin
            // shamt is 6 bits on RV64; on RV32 inst[25] must be clear
            w_imm = {58'd0, i_inst[25:20]};
            if (i_inst[31:26] == 6'b000000 && (RV64 || !i_inst[25])) w_func = ALU_SLLI;
            else                                                     w_ill  = 1'b1;
          end
          3'b101: begin
            w_imm = {58'd0, i_inst[25:20]};
            if (!RV64 && i_inst[25])                w_ill  = 1'b1;
            else if (i_inst[31:26] == 6'b000000)    w_func = ALU_SRLI;
            else if (i_inst[31:26] == 6'b010000)    w_func = ALU_SRAI;
            else                                    w_ill  = 1'b1;
          end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_OP: begin
        w_op = OP_REG; w_fu = FU_ALU;
        case (w_fun7)
          7'b0000000: begin
            case (w_fun3)
              3'b000:  w_func = ALU_ADD;
              3'b001:  w_func = ALU_SLL;
              3'b010:  w_func = ALU_SLT;
              3'b011:  w_func = ALU_SLTU;
              3'b100:  w_func = ALU_XOR;
              3'b101:  w_func = ALU_SRL;
              3'b110:  w_func = ALU_OR;
              3'b111:  w_func = ALU_AND;
              default: w_ill  = 1'b1;
            endcase
          end
          7'b0100000: begin
            case (w_fun3)
              3'b000:  w_func = ALU_SUB;
              3'b101:  w_func = ALU_SRA;
              default: w_ill  = 1'b1;
            endcase
          end
          7'b0000001: begin
            w_fu = FU_MDU;
            if (EN_M) begin
              case (w_fun3)
                3'b000:  w_func = MDU_MUL;
                3'b001:  w_func = MDU_MULH;
                3'b010:  w_func = MDU_MULHSU;
                3'b011:  w_func = MDU_MULHU;
                3'b100:  w_func = MDU_DIV;
                3'b101:  w_func = MDU_DIVU;
                3'b110:  w_func = MDU_REM;
                3'b111:  w_func = MDU_REMU;
                default: w_ill  = 1'b1;
              endcase
            end else begin
              w_ill = 1'b1;
            end
          end
          default: w_ill = 1'b1;
        endcase
      end
      OPC_OP_IMM_32: begin
        w_op = OP_IMM; w_fu = FU_ALU;
        w_imm = imm_i(i_inst[31:20]);
        if (!RV64) begin
          w_ill = 1'b1;
        end else begin
          case (w_fun3)
            3'b000: w_func = ALU_ADDIW;
            3'b001: begin
              w_imm = {59'd0, i_inst[24:20]};
              if (w_fun7 == 7'b0000000) w_func = ALU_SLLIW;
              else                      w_ill  = 1'b1;
            end
            3'b101: begin
              w_imm = {59'd0, i_inst[24:20]};
              if (w_fun7 == 7'b0000000)      w_func = ALU_SRLIW;
              else if (w_fun7 == 7'b0100000) w_func = ALU_SRAIW;
              else                           w_ill  = 1'b1;
            end
            default: w_ill = 1'b1;
          endcase
        end
      end
      OPC_OP_32: begin
        w_op = OP_REG; w_fu = FU_ALU;
        if (!RV64) begin
          w_ill = 1'b1;
        end else begin
          case (w_fun7)
            7'b0000000: begin
              case (w_fun3)
                3'b000:  w_func = ALU_ADDW;
                3'b001:  w_func = ALU_SLLW;
                3'b101:  w_func = ALU_SRLW;
                default: w_ill  = 1'b1;
              endcase
            end
            7'b0100000: begin
              case (w_fun3)
                3'b000:  w_func = ALU_SUBW;
                3'b101:  w_func = ALU_SRAW;
                default: w_ill  = 1'b1;
              endcase
            end
            7'b0000001: begin
              w_fu = FU_MDU;
              if (EN_M) begin
                case (w_fun3)
                  3'b000:  w_func = MDU_MULW;
                  3'b100:  w_func = MDU_DIVW;
                  3'b101:  w_func = MDU_DIVUW;
                  3'b110:  w_func = MDU_REMW;
                  3'b111:  w_func = MDU_REMUW;
                  default: w_ill  = 1'b1;
                endcase
              end else begin
                w_ill = 1'b1;
              end
            end
            default: w_ill = 1'b1;
          endcase
        end
      end
      OPC_MISC_MEM: begin
        w_op = OP_FENCE; w_fu = FU_SYS; w_func = SYS_FENCE;
        if (w_fun3 != 3'b000) w_ill = 1'b1;
        else                  w_ill = 1'b0;
      end
      OPC_SYSTEM: begin
        // Only ecall/ebreak are supported; CSR accesses trap as illegal
        w_op = OP_SYSTEM; w_fu = FU_SYS;
        if (i_inst == 32'h0000_0073)      w_func = SYS_ECALL;
        else if (i_inst == 32'h0010_0073) w_func = SYS_EBREAK;
        else                              w_ill  = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Assemble the uop record; illegal uops carry no unit, function or writeback
  always_comb begin
    o_uop         = '0;
    o_uop.pc      = 64'(i_pc);
    o_uop.inst    = i_inst;
    o_uop.rs1     = i_inst[19:15];
    o_uop.rs2     = i_inst[24:20];
    o_uop.rd      = i_inst[11:7];
    o_uop.imm     = w_imm;
    o_uop.illegal = w_ill;
    o_uop.ecall   = (i_inst == 32'h0000_0073);
    o_uop.ebreak  = (i_inst == 32'h0010_0073);
    o_uop.rd_wen  = (w_opc != OPC_BRANCH) && (w_opc != OPC_STORE) &&
                    (i_inst[11:7] != 5'd0) && !w_ill;
    if (w_ill) begin
      o_uop.op   = OP_NONE;
      o_uop.fu   = FU_NONE;
      o_uop.func = FUNC_NONE;
    end else begin
      o_uop.op   = w_op;
      o_uop.fu   = w_fu;
      o_uop.func = w_func;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Buffered decode stage: circular instruction FIFO feeding a combinational
// decoder, with the result held in a registered valid/ready output slot.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IBUF_DEPTH = 4,
  parameter bit EN_M       = 1'b1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          fetch_valid_i,
  output logic                          fetch_ready_o,
  input  logic [XLEN-1:0]               pc_i,
  input  logic [31:0]                   inst_i,
  output logic                          uop_valid_o,
  input  logic                          uop_ready_i,
  output uop_info_t                     uop_info_o,
  output logic [$clog2(IBUF_DEPTH):0]   ibuf_count_o
);

  localparam int              PTR_W   = $clog2(IBUF_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(IBUF_DEPTH);

  logic [XLEN-1:0]  r_pc_mem   [IBUF_DEPTH];
  logic [31:0]      r_inst_mem [IBUF_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_uop_valid;
  uop_info_t        r_uop_info;

  uop_info_t        w_dec_uop;
  logic             w_enq;
  logic             w_load;
  logic             w_head_valid;

  // Ready depends only on occupancy and flush, never on the consumer
  assign fetch_ready_o = !flush_i && (r_count < DEPTH_C);
  assign w_enq         = fetch_valid_i && fetch_ready_o;
  assign w_head_valid  = (r_count != '0);
  // Head moves into the slot when the slot is empty or draining this cycle
  assign w_load        = w_head_valid && (!r_uop_valid || uop_ready_i) && !flush_i;

  rv_decode_core #(
    .XLEN (XLEN),
    .EN_M (EN_M)
  ) u_core (
    .i_pc   (r_pc_mem[r_rd_ptr]),
    .i_inst (r_inst_mem[r_rd_ptr]),
    .o_uop  (w_dec_uop)
  );

  // Buffer storage write; contents need no reset since pointers qualify them
  always_ff @(posedge clk_i) begin
    if (!rst_i && w_enq) begin
      r_pc_mem[r_wr_ptr]   <= pc_i;
      r_inst_mem[r_wr_ptr] <= inst_i;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_load) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_enq && !w_load)      r_count <= r_count + (PTR_W+1)'(1);
      else if (!w_enq && w_load) r_count <= r_count - (PTR_W+1)'(1);
    end
  end

  // Output slot: holds its uop until taken, reloads on the same edge it drains
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_uop_valid <= 1'b0;
      r_uop_info  <= '0;
    end else if (flush_i) begin
      r_uop_valid <= 1'b0;
    end else if (w_load) begin
      r_uop_valid <= 1'b1;
      r_uop_info  <= w_dec_uop;
    end else if (uop_ready_i) begin
      r_uop_valid <= 1'b0;
    end
  end

  assign uop_valid_o  = r_uop_valid;
  assign uop_info_o   = r_uop_info;
  assign ibuf_count_o = r_count;

endmodule
